// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial magnitude comparator.
package serial_mag_compare_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to hold WIDTH-1 as a down-counter (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(width)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_one_bit_comparator.sv
// Single-bit magnitude compare stage with less/eq/greater chain in and out.
module one_bit_comparator (
  input  logic a,
  input  logic b,
  input  logic less_in,
  input  logic eq_in,
  input  logic greater_in,
  output logic less_out,
  output logic eq_out,
  output logic greater_out
);

  // Once a higher bit has decided the result, it passes straight through.
  assign less_out    = less_in    | (eq_in & ~a &  b);
  assign greater_out = greater_in | (eq_in &  a & ~b);
  assign eq_out      = eq_in & ~(a ^ b);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial MSB-first unsigned magnitude compare sequencer around one
// one_bit_comparator cell, with registered result and one-cycle done pulse.
module serial_mag_compare_ctrl
  import serial_mag_compare_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             eq,
  output logic             greater
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;
  logic             r_busy;
  logic             r_done;
  logic             r_less;
  logic             r_eq_res;
  logic             r_greater;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_sh_nxt;
  logic [WIDTH-1:0] w_b_sh_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_lt_nxt;
  logic             w_eq_nxt;
  logic             w_gt_nxt;
  logic             w_less_nxt;
  logic             w_eq_res_nxt;
  logic             w_greater_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic             w_cell_lt;
  logic             w_cell_eq;
  logic             w_cell_gt;

  one_bit_comparator u_cell (
    .a           (r_a_sh[WIDTH-1]),
    .b           (r_b_sh[WIDTH-1]),
    .less_in     (r_lt),
    .eq_in       (r_eq),
    .greater_in  (r_gt),
    .less_out    (w_cell_lt),
    .eq_out      (w_cell_eq),
    .greater_out (w_cell_gt)
  );

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_cnt     <= '0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_less    <= 1'b0;
      r_eq_res  <= 1'b0;
      r_greater <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a_sh    <= w_a_sh_nxt;
      r_b_sh    <= w_b_sh_nxt;
      r_cnt     <= w_cnt_nxt;
      r_lt      <= w_lt_nxt;
      r_eq      <= w_eq_nxt;
      r_gt      <= w_gt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_less    <= w_less_nxt;
      r_eq_res  <= w_eq_res_nxt;
      r_greater <= w_greater_nxt;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_a_sh_nxt    = r_a_sh;
    w_b_sh_nxt    = r_b_sh;
    w_cnt_nxt     = r_cnt;
    w_lt_nxt      = r_lt;
    w_eq_nxt      = r_eq;
    w_gt_nxt      = r_gt;
    w_less_nxt    = r_less;
    w_eq_res_nxt  = r_eq_res;
    w_greater_nxt = r_greater;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_a_sh_nxt  = a;
          w_b_sh_nxt  = b;
          w_lt_nxt    = 1'b0;
          w_eq_nxt    = 1'b1;
          w_gt_nxt    = 1'b0;
          w_cnt_nxt   = CW'(WIDTH - 1);
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_lt_nxt   = w_cell_lt;
        w_eq_nxt   = w_cell_eq;
        w_gt_nxt   = w_cell_gt;
        w_a_sh_nxt = {r_a_sh[WIDTH-2:0], 1'b0};
        w_b_sh_nxt = {r_b_sh[WIDTH-2:0], 1'b0};
        // Exit on the last bit, or as soon as the chain has decided.
        if ((r_cnt == '0) || (EARLY_EXIT && !w_cell_eq)) begin
          w_less_nxt    = w_cell_lt;
          w_eq_res_nxt  = w_cell_eq;
          w_greater_nxt = w_cell_gt;
          w_state_nxt   = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign less    = r_less;
  assign eq      = r_eq_res;
  assign greater = r_greater;

endmodule
